// File: rtl/spi_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_sram_pkg
// Description : Shared types and defaults for the SPI serial-SRAM frame logic.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_sram_pkg;

    localparam int          c_DEF_ADDR_W   = 4;
    localparam int          c_DEF_DATA_W   = 8;
    localparam logic [7:0]  c_DEF_OP_WRITE = 8'h02;
    localparam logic [7:0]  c_DEF_OP_READ  = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WDATA = 3'd3,
        ST_TURN  = 3'd4,
        ST_RDATA = 3'd5,
        ST_HOLD  = 3'd6
    } state_t;

    function automatic int cnt_width(input int aw, input int dw);
        int m;
        m = 8;
        if (aw > m) m = aw;
        if (dw > m) m = dw;
        return $clog2(m) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : spi_bit_counter
// Description : Loadable down-counter with a zero flag for SPI bit tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/spi_sram_frame.sv
`default_nettype none
// ============================================================================
// Module      : spi_sram_frame
// Description : SPI-slave frame sequencer driving a serial SRAM (opcode,
//               address, write/read data). Define SPI_SRAM_BURST_EN for
//               auto-incrementing multi-byte bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sram_frame
    import spi_sram_pkg::*;
#(
    parameter int         ADDR_W   = c_DEF_ADDR_W,
    parameter int         DATA_W   = c_DEF_DATA_W,
    parameter logic [7:0] OP_WRITE = c_DEF_OP_WRITE,
    parameter logic [7:0] OP_READ  = c_DEF_OP_READ
) (
    input  logic              sck,
    input  logic              rstn,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we,
    output logic              sram_re,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              busy
);

    localparam int c_CNT_W = cnt_width(ADDR_W, DATA_W);

`ifdef SPI_SRAM_BURST_EN
    localparam bit c_BURST = 1'b1;
`else
    localparam bit c_BURST = 1'b0;
`endif

    state_t              r_state;
    logic [7:0]          r_op;
    logic [DATA_W-1:0]   r_tx;
    logic                r_miso;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_we;
    logic                r_re;

    logic                w_load;
    logic                w_dec;
    logic [c_CNT_W-1:0]  w_load_val;
    logic                w_zero;
    logic [7:0]          w_op_next;

    assign w_op_next = {r_op[6:0], mosi};

    // Counter reloads on every state entry; the zero flag marks the last bit.
    always_comb begin
        w_load     = 1'b0;
        w_dec      = 1'b0;
        w_load_val = '0;
        if (!ss_n) begin
            case (r_state)
                ST_IDLE: begin
                    w_load     = 1'b1;
                    w_load_val = c_CNT_W'(6);
                end
                ST_CMD: begin
                    if (w_zero) begin
                        w_load     = 1'b1;
                        w_load_val = c_CNT_W'(ADDR_W - 1);
                    end else begin
                        w_dec = 1'b1;
                    end
                end
                ST_ADDR, ST_WDATA: begin
                    if (w_zero) begin
                        w_load     = 1'b1;
                        w_load_val = c_CNT_W'(DATA_W - 1);
                    end else begin
                        w_dec = 1'b1;
                    end
                end
                ST_TURN: begin
                    w_load     = 1'b1;
                    w_load_val = c_CNT_W'(DATA_W - 2);
                end
                ST_RDATA: begin
                    w_dec = ~w_zero;
                end
                default: begin
                    w_dec = 1'b0;
                end
            endcase
        end
    end

    spi_bit_counter #(
        .WIDTH (c_CNT_W)
    ) u_bit_counter (
        .clk        (sck),
        .rstn       (rstn),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge sck) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_tx    <= '0;
            r_miso  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
        end else if (ss_n) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_miso  <= 1'b0;
        end else begin
            r_we <= 1'b0;
            r_re <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_op    <= {7'b0, mosi};
                    r_state <= ST_CMD;
                end
                ST_CMD: begin
                    r_op <= w_op_next;
                    if (w_zero) begin
                        if (w_op_next == OP_WRITE || w_op_next == OP_READ) begin
                            r_state <= ST_ADDR;
                        end else begin
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_ADDR: begin
                    r_addr <= (r_addr << 1) | ADDR_W'(mosi);
                    if (w_zero) begin
                        if (r_op == OP_WRITE) begin
                            r_state <= ST_WDATA;
                        end else begin
                            r_re    <= 1'b1;
                            r_state <= ST_TURN;
                        end
                    end
                end
                ST_WDATA: begin
                    // Burst: bump the address only after the strobe cycle has passed.
                    if (r_we) begin
                        r_addr <= r_addr + 1'b1;
                    end
                    r_wdata <= (r_wdata << 1) | DATA_W'(mosi);
                    if (w_zero) begin
                        r_we    <= 1'b1;
                        r_state <= c_BURST ? ST_WDATA : ST_HOLD;
                    end
                end
                ST_TURN: begin
                    r_tx    <= sram_rdata;
                    r_miso  <= sram_rdata[DATA_W-1];
                    r_state <= ST_RDATA;
                end
                ST_RDATA: begin
                    r_tx   <= r_tx << 1;
                    r_miso <= r_tx[DATA_W-2];
                    if (w_zero) begin
                        if (c_BURST) begin
                            r_addr  <= r_addr + 1'b1;
                            r_re    <= 1'b1;
                            r_state <= ST_TURN;
                        end else begin
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    r_miso <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign miso       = r_miso;
    assign sram_addr  = r_addr;
    assign sram_wdata = r_wdata;
    assign sram_we    = r_we;
    assign sram_re    = r_re;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_sram_frame.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_sram_frame
// Description : Self-checking bench for spi_sram_frame (vector table, random
//               frames against a memory-level model, hand-written corners).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_sram_frame;

`ifdef SPI_SRAM_BURST_EN
    localparam int c_RD_STROBES = 2;
`else
    localparam int c_RD_STROBES = 1;
`endif

    typedef struct {
        int         idx;
        logic [3:0] a;
        logic [7:0] d;
    } ev_t;

    typedef struct {
        logic [7:0] op;
        logic [3:0] a;
        logic [7:0] d;
        int         exp_we;
        int         exp_re;
        logic [7:0] exp_miso;
    } vec_t;

    logic       sck = 1'b0;
    logic       rstn = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [3:0] sram_addr;
    logic [7:0] sram_wdata;
    logic       sram_we;
    logic       sram_re;
    logic [7:0] sram_rdata;
    logic       busy;

    logic [7:0] mem     [16];
    logic [7:0] ref_mem [16];

    ev_t  we_log[$];
    ev_t  re_log[$];
    logic miso_log[$];
    logic busy_log[$];
    int   tick_idx;
    int   both_err = 0;
    int   checks = 0;
    int   errors = 0;

    assign sram_rdata = mem[sram_addr];

    spi_sram_frame dut (
        .sck        (sck),
        .rstn       (rstn),
        .ss_n       (ss_n),
        .mosi       (mosi),
        .miso       (miso),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_we    (sram_we),
        .sram_re    (sram_re),
        .sram_rdata (sram_rdata),
        .busy       (busy)
    );

    always #5 sck = ~sck;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Record outputs of the last posedge, act as the SRAM, then drive inputs.
    task automatic tick(input logic s, input logic m);
        ev_t e;
        @(negedge sck);
        if (sram_we && sram_re) both_err++;
        if (sram_we) begin
            e.idx = tick_idx; e.a = sram_addr; e.d = sram_wdata;
            we_log.push_back(e);
            mem[sram_addr] = sram_wdata;
        end
        if (sram_re) begin
            e.idx = tick_idx; e.a = sram_addr; e.d = sram_rdata;
            re_log.push_back(e);
        end
        miso_log.push_back(miso);
        busy_log.push_back(busy);
        tick_idx++;
        ss_n = s;
        mosi = m;
    endtask

    task automatic start_log();
        we_log.delete();
        re_log.delete();
        miso_log.delete();
        busy_log.delete();
        tick_idx = 0;
    endtask

    task automatic send(input logic [31:0] bits, input int n, input int extra_low);
        start_log();
        for (int i = n - 1; i >= 0; i--) tick(1'b0, bits[i]);
        for (int i = 0; i < extra_low; i++) tick(1'b0, 1'($urandom));
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    endtask

    function automatic vec_t model(input logic [7:0] op, input logic [3:0] a, input logic [7:0] d);
        vec_t v;
        v.op       = op;
        v.a        = a;
        v.d        = d;
        v.exp_we   = (op == 8'h02) ? 1 : 0;
        v.exp_re   = (op == 8'h03) ? c_RD_STROBES : 0;
        v.exp_miso = (op == 8'h03) ? ref_mem[a] : 8'h00;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        logic [7:0] mb;
        send({4'b0, v.op, v.a, v.d}, 20, 0);
        chk({tag, "/we_cnt"}, we_log.size(), v.exp_we);
        chk({tag, "/re_cnt"}, re_log.size(), v.exp_re);
        if (v.exp_we > 0 && we_log.size() > 0) begin
            chk({tag, "/we_cycle"}, we_log[0].idx, 20);
            chk({tag, "/we_addr"}, int'(we_log[0].a), int'(v.a));
            chk({tag, "/we_data"}, int'(we_log[0].d), int'(v.d));
        end
        if (v.exp_re > 0 && re_log.size() > 0) begin
            chk({tag, "/re_cycle"}, re_log[0].idx, 12);
            chk({tag, "/re_addr"}, int'(re_log[0].a), int'(v.a));
        end
        for (int k = 0; k < 8; k++) mb[7-k] = miso_log[13+k];
        chk({tag, "/miso_byte"}, int'(mb), int'(v.exp_miso));
        chk({tag, "/busy_hold"}, int'(busy_log[20]), 1);
        chk({tag, "/busy_idle"}, int'(busy_log[21]), 0);
        if (v.op == 8'h02) ref_mem[v.a] = v.d;
    endtask

    initial begin
        vec_t tbl[13];
        vec_t v;
        logic [7:0] b;
        logic [11:0] hb;

        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            mem[i] = b;
            ref_mem[i] = b;
        end

        tbl[0]  = '{8'h02, 4'hA, 8'h5C, 1, 0, 8'h00};
        tbl[1]  = '{8'h03, 4'hA, 8'h00, 0, c_RD_STROBES, 8'h5C};
        tbl[2]  = '{8'h02, 4'h3, 8'hC9, 1, 0, 8'h00};
        tbl[3]  = '{8'h03, 4'h3, 8'h00, 0, c_RD_STROBES, 8'hC9};
        tbl[4]  = '{8'h7F, 4'h5, 8'hAA, 0, 0, 8'h00};
        tbl[5]  = '{8'h02, 4'h0, 8'hFF, 1, 0, 8'h00};
        tbl[6]  = '{8'h03, 4'h0, 8'h12, 0, c_RD_STROBES, 8'hFF};
        tbl[7]  = '{8'h02, 4'hF, 8'h00, 1, 0, 8'h00};
        tbl[8]  = '{8'h03, 4'hF, 8'hFF, 0, c_RD_STROBES, 8'h00};
        tbl[9]  = '{8'h00, 4'h1, 8'h12, 0, 0, 8'h00};
        tbl[10] = '{8'hFF, 4'h2, 8'h34, 0, 0, 8'h00};
        tbl[11] = '{8'h01, 4'h6, 8'h56, 0, 0, 8'h00};
        tbl[12] = '{8'h83, 4'h7, 8'h78, 0, 0, 8'h00};

        // Reset state
        start_log();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        chk("rst/miso", int'(miso), 0);
        chk("rst/addr", int'(sram_addr), 0);
        chk("rst/wdata", int'(sram_wdata), 0);
        chk("rst/we", int'(sram_we), 0);
        chk("rst/re", int'(sram_re), 0);
        chk("rst/busy", int'(busy), 0);
        rstn = 1'b1;
        tick(1'b1, 1'b0);

        for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Abort after 3 of 8 data bits, then a clean write and read-back
        send({12'b0, 8'h02, 4'hA, 3'b101}, 15, 0);
        chk("abort/we_cnt", we_log.size(), 0);
        chk("abort/busy_before", int'(busy_log[15]), 1);
        chk("abort/busy_idle", int'(busy_log[16]), 0);
        run_vec(model(8'h02, 4'h6, 8'hA5), "after_abort_wr");
        run_vec(model(8'h03, 4'h6, 8'h00), "after_abort_rd");

        // Reset in the middle of the address phase
        start_log();
        hb = {8'h02, 4'hF};
        for (int i = 11; i >= 1; i--) tick(1'b0, hb[i]);
        rstn = 1'b0;
        tick(1'b1, 1'b0);
        chk("midrst/miso", int'(miso), 0);
        chk("midrst/addr", int'(sram_addr), 0);
        chk("midrst/wdata", int'(sram_wdata), 0);
        chk("midrst/we", int'(sram_we), 0);
        chk("midrst/re", int'(sram_re), 0);
        chk("midrst/busy", int'(busy), 0);
        chk("midrst/no_we", we_log.size(), 0);
        rstn = 1'b1;
        tick(1'b1, 1'b0);
        run_vec(model(8'h03, 4'hF, 8'h00), "after_rst_rd");
        run_vec(model(8'h02, 4'h9, 8'h3C), "after_rst_wr");

        // Two data bytes at the top address
        send({4'b0, 8'h02, 4'hF, 8'h11, 8'h22}, 28, 0);
        chk("burst/we0_addr", (we_log.size() > 0) ? int'(we_log[0].a) : -1, 15);
        chk("burst/we0_data", (we_log.size() > 0) ? int'(we_log[0].d) : -1, 8'h11);
        ref_mem[4'hF] = 8'h11;
`ifdef SPI_SRAM_BURST_EN
        chk("burst/we_cnt", we_log.size(), 2);
        chk("burst/we1_addr", (we_log.size() > 1) ? int'(we_log[1].a) : -1, 0);
        chk("burst/we1_data", (we_log.size() > 1) ? int'(we_log[1].d) : -1, 8'h22);
        chk("burst/we1_cycle", (we_log.size() > 1) ? we_log[1].idx : -1, 28);
        ref_mem[4'h0] = 8'h22;
`else
        chk("burst/we_cnt", we_log.size(), 1);
`endif
        run_vec(model(8'h03, 4'h0, 8'h00), "burst_rd0");
        run_vec(model(8'h03, 4'hF, 8'h00), "burst_rdF");

        // Random frames against the memory-level model
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    b = 8'h02;
                2:       b = 8'h03;
                default: b = 8'($urandom);
            endcase
            v = model(b, 4'($urandom), 8'($urandom));
            run_vec(v, $sformatf("rnd%0d_op%02h", i, b));
        end

        chk("we_re_exclusive", both_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
